instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the control unit. Holds the PC and fetches 32-bit words over a req/ack instruction-memory port.

---
 rtl/instr_fetch_unit_if.sv | 11 +
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory port of the fetch stage: req/addr held until ack,
// with ack allowed in the same cycle as req.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, req/ack instruction fetch, decode field split, redirects.
// Optional FETCH_ALIGN_CHK_EN: misaligned redirects set sticky misalign_err and halt fetch.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic                      instr_valid,
    output logic [31:0]               instr,
    output logic [31:0]               pc_out,
    output logic [31:0]               pc_plus4,
    output logic [5:0]                opcode,
    output logic [5:0]                funct,
    output logic [4:0]                rs,
    output logic [4:0]                rt,
    output logic [4:0]                rd,
    output logic [4:0]                shamt,
    output logic [15:0]               imm,
    output logic [25:0]               jtarget,
    output logic                      misalign_err
);

    typedef enum logic [1:0] {START, FETCH, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] fetch_pc, fetch_pc_nx;
    logic [31:0] target, target_nx;
    logic        valid_nx, err_nx, cap, req;
    logic [31:0] rpc;
    logic        bad;

`ifdef FETCH_ALIGN_CHK_EN
    assign rpc = redirect_pc;
    assign bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign rpc = redirect_pc & 32'hFFFF_FFFC;
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= START;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        target_nx   = target;
        valid_nx    = instr_valid;
        err_nx      = misalign_err;
        cap         = 1'b0;
        req         = 1'b0;

        if (instr_valid && !stall) valid_nx = 1'b0;

        case (state)
            START: begin
                state_nx = FETCH;
                if (redirect_valid && !bad) fetch_pc_nx = rpc;
            end
            FETCH: begin
                // Gating on stall keeps the output slot free whenever an ack can land.
                req = !(instr_valid && stall) && !misalign_err;
                if (redirect_valid) begin
                    if (req && !imem.imem_ack) begin
                        state_nx  = DRAIN;
                        target_nx = bad ? fetch_pc : rpc;
                    end else if (!bad) begin
                        fetch_pc_nx = rpc;
                    end
                end else if (req && imem.imem_ack) begin
                    cap         = 1'b1;
                    valid_nx    = 1'b1;
                    fetch_pc_nx = fetch_pc + 32'd4;
                end
            end
            DRAIN: begin
                req = 1'b1;
                if (imem.imem_ack) begin
                    state_nx    = FETCH;
                    fetch_pc_nx = (redirect_valid && !bad) ? rpc : target;
                end else if (redirect_valid && !bad) begin
                    target_nx = rpc;
                end
            end
            default: state_nx = START;
        endcase

        if (redirect_valid) begin
            valid_nx = 1'b0;
            if (bad) err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            target       <= '0;
            instr_valid  <= 1'b0;
            instr        <= '0;
            pc_out       <= '0;
            misalign_err <= 1'b0;
        end else begin
            fetch_pc     <= fetch_pc_nx;
            target       <= target_nx;
            instr_valid  <= valid_nx;
            misalign_err <= err_nx;
            if (cap) begin
                instr  <= imem.imem_rdata;
                pc_out <= fetch_pc;
            end
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc;

    assign pc_plus4 = pc_out + 32'd4;
    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign imm      = instr[15:0];
    assign jtarget  = instr[25:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios plus randomized
// stall/redirect/wait-state traffic against a sequential-PC reference model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr, pc_out, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] jtarget;
    logic        misalign_err;

    instr_fetch_unit_if imem();

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .imem(imem),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .jtarget(jtarget), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_cons = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: fixed word at 0, hashed words elsewhere.
    function automatic logic [31:0] memw(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C22_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory responder with configurable wait states.
    int   wcnt = 0;
    int   wreq = 0;
    int   fixed_wait = 0;
    int   max_wait = 0;
    logic late_ack = 1'b0;
    logic r_hs, r_pend;

    function automatic int pick_wait();
        if (fixed_wait >= 0) return fixed_wait;
        return int'($urandom_range(max_wait, 0));
    endfunction

    assign imem.imem_ack   = (imem.imem_req && (wcnt >= wreq)) || late_ack;
    assign imem.imem_rdata = (imem.imem_req && (wcnt >= wreq)) ? memw(imem.imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        r_hs   = imem.imem_req && imem.imem_ack;
        r_pend = imem.imem_req && !imem.imem_ack;
        #1;
        if (!rst_n || r_hs) begin
            wcnt = 0;
            wreq = pick_wait();
        end else if (r_pend) begin
            wcnt++;
        end
    end

    // Reference model: expected PCs of upcoming consumed instructions.
    logic [31:0] exp_q[$];
    logic        exp_err = 1'b0;

    logic        pend_prev = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] addr_prev, instr_prev, pc_prev;
    logic [31:0] e_pc, e_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend_prev = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (pend_prev) begin
                chk1("req_held", imem.imem_req, 1'b1);
                chk("addr_held", imem.imem_addr, addr_prev);
            end
            if (hold_prev) begin
                chk("stall_instr_hold", instr, instr_prev);
                chk("stall_pc_hold", pc_out, pc_prev);
            end
            if (instr_valid && stall) chk1("stall_req_gate", imem.imem_req, 1'b0);
            chk1("misalign_err", misalign_err, exp_err);

            if (instr_valid && !stall && !redirect_valid) begin
                n_cons++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard: consumed pc %h with nothing expected", pc_out);
                end else begin
                    e_pc = exp_q.pop_front();
                    e_w  = memw(e_pc);
                    chk("pc_out", pc_out, e_pc);
                    chk("instr", instr, e_w);
                    chk("pc_plus4", pc_plus4, e_pc + 32'd4);
                    chk("opcode", 32'(opcode), e_w >> 26);
                    chk("funct", 32'(funct), e_w & 32'h3F);
                    chk("rs", 32'(rs), (e_w >> 21) & 32'h1F);
                    chk("rt", 32'(rt), (e_w >> 16) & 32'h1F);
                    chk("rd", 32'(rd), (e_w >> 11) & 32'h1F);
                    chk("shamt", 32'(shamt), (e_w >> 6) & 32'h1F);
                    chk("imm", 32'(imm), e_w & 32'hFFFF);
                    chk("jtarget", 32'(jtarget), e_w & 32'h03FF_FFFF);
                    exp_q.push_back(e_pc + 32'd4);
                end
            end

            pend_prev  = imem.imem_req && !imem.imem_ack;
            addr_prev  = imem.imem_addr;
            hold_prev  = instr_valid && stall && !redirect_valid;
            instr_prev = instr;
            pc_prev    = pc_out;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        late_ack = 1'b1;
        redirect_valid = 1'b0;
        stall = 1'b0;
        exp_err = 1'b0;
        #1;
        chk1("rst_req", imem.imem_req, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_fields", {26'(opcode), rs}, 32'h0);
        chk1("rst_misalign", misalign_err, 1'b0);
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        late_ack = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] t, input logic [31:0] model_pc);
        redirect_valid = 1'b1;
        redirect_pc = t;
        exp_q.delete();
        exp_q.push_back(model_pc);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    logic [31:0] p_rec, tgt;

    initial begin
        // 1: zero-wait streaming from reset
        fixed_wait = 0;
        do_reset();
        @(negedge clk);
        chk1("t1_req", imem.imem_req, 1'b1);
        chk("t1_addr0", imem.imem_addr, 32'h0);
        @(negedge clk);
        chk("t1_addr4", imem.imem_addr, 32'h4);
        chk1("t1_valid0", instr_valid, 1'b1);
        chk("t1_opcode", 32'(opcode), 32'h23);
        chk("t1_rs", 32'(rs), 32'h1);
        chk("t1_rt", 32'(rt), 32'h2);
        chk("t1_imm", 32'(imm), 32'h4);
        chk("t1_pc_plus4", pc_plus4, 32'h4);
        @(negedge clk);
        chk("t1_addr8", imem.imem_addr, 32'h8);
        chk1("t1_valid1", instr_valid, 1'b1);
        chk("t1_pc4", pc_out, 32'h4);

        // 2: three-cycle stall
        @(posedge clk); #1;
        stall = 1'b1;
        @(negedge clk);
        p_rec = pc_out;
        repeat (3) @(posedge clk);
        #1;
        stall = 1'b0;
        @(negedge clk);
        chk("t2_pc_after_stall", pc_out, p_rec);
        @(negedge clk);
        chk("t2_pc_next", pc_out, p_rec + 32'd4);

        // 3: redirect while a 2-wait request at 0x8 is outstanding
        fixed_wait = 2;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 40 && !(imem.imem_req && imem.imem_addr == 32'h8); i++) @(negedge clk);
        chk("t3_reach_addr8", imem.imem_addr, 32'h8);
        @(posedge clk); #1;
        pulse_redirect(32'h40, 32'h40);
        @(negedge clk);
        chk1("t3_drain_req", imem.imem_req, 1'b1);
        chk("t3_drain_addr", imem.imem_addr, 32'h8);
        chk1("t3_drain_valid", instr_valid, 1'b0);
        for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
        chk("t3_first_pc", pc_out, 32'h40);

        // 4: redirect coinciding with ack at 0xC, then redirect to the top word
        fixed_wait = 0;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 20 && imem.imem_addr != 32'h8; i++) @(negedge clk);
        @(posedge clk); #1;
        chk("t4_addrC", imem.imem_addr, 32'hC);
        pulse_redirect(32'h40, 32'h40);
        @(negedge clk);
        chk("t4_addr40", imem.imem_addr, 32'h40);
        chk1("t4_flushed", instr_valid, 1'b0);
        @(posedge clk); #1;
        pulse_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t4_addr_top", imem.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t4_pc_top", pc_out, 32'hFFFF_FFFC);
        chk("t4_wrap_plus4", pc_plus4, 32'h0);
        chk("t4_wrap_addr", imem.imem_addr, 32'h0);

        // 5: misaligned redirect
        @(posedge clk); #1;
`ifdef FETCH_ALIGN_CHK_EN
        pulse_redirect(32'h42, 32'h0);
        exp_q.delete();
        exp_err = 1'b1;
        @(negedge clk);
        chk1("t5_err", misalign_err, 1'b1);
        chk1("t5_req_off", imem.imem_req, 1'b0);
        chk1("t5_valid_off", instr_valid, 1'b0);
        repeat (3) @(negedge clk);
        chk1("t5_still_off", imem.imem_req, 1'b0);
`else
        pulse_redirect(32'h42, 32'h40);
        @(negedge clk);
        for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
        chk("t5_masked_pc", pc_out, 32'h40);
        chk1("t5_no_err", misalign_err, 1'b0);
`endif

        // 6: reset during DRAIN with the ack still pending
        fixed_wait = 5;
        do_reset();
        @(posedge clk); #1;
        pulse_redirect(32'h80, 32'h80);
        @(negedge clk);
        chk1("t6_in_drain_req", imem.imem_req, 1'b1);
        chk1("t6_in_drain_valid", instr_valid, 1'b0);
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 10 && !imem.imem_req; i++) @(negedge clk);
        chk("t6_first_addr", imem.imem_addr, RESET_PC);
        for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
        chk("t6_first_pc", pc_out, RESET_PC);
        chk("t6_first_instr", instr, 32'h8C22_0004);

        // Randomized stall / redirect / wait-state traffic
        fixed_wait = -1;
        max_wait = 2;
        do_reset();
        n_cons = 0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            stall = ($urandom_range(3, 0) == 0);
            if (redirect_valid) redirect_valid = 1'b0;
            if ($urandom_range(19, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0: tgt = 32'h40;
                    1: tgt = 32'hFFFF_FFF4;
                    default: tgt = $urandom;
                endcase
`ifdef FETCH_ALIGN_CHK_EN
                tgt = tgt & 32'hFFFF_FFFC;
`endif
                redirect_valid = 1'b1;
                redirect_pc = tgt;
                exp_q.delete();
                exp_q.push_back(tgt & 32'hFFFF_FFFC);
            end
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        stall = 1'b0;
        repeat (10) @(posedge clk);
        chk1("random_progress", n_cons > 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
